// File: rtl/counter_pkg.sv
// Shared constants and next-value helpers for the up/down counter family.
// The helpers work on plain unsigned integers so any counter width can reuse
// them; callers truncate the result back to their own width.
package counter_pkg;

  localparam int COUNT_WIDTH = 4;
  localparam int MOD_BIN4    = 16;
  localparam int MOD_BCD     = 10;

  // Limit a parallel-load value to the legal range 0..modulus-1.
  function automatic int unsigned clamp_value(input int unsigned value,
                                              input int unsigned modulus);
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

  // Decrement with wrap (or hold at zero when saturating). An out-of-range
  // value recovers to the top of the range.
  function automatic int unsigned down_next(input int unsigned value,
                                            input int unsigned modulus,
                                            input bit          saturate);
    if (value >= modulus) return modulus - 1;
    if (value == 0)       return saturate ? 0 : modulus - 1;
    return value - 1;
  endfunction

  // Increment with wrap; an out-of-range value recovers to zero.
  function automatic int unsigned up_next(input int unsigned value,
                                          input int unsigned modulus);
    return (value >= modulus - 1) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/down_counter.sv
// Synchronous cascadable down counter, range 0..MODULUS-1.
// Priority per edge: clear (active low) > load > preset > enable > hold.
// borrow = enable & (q == 0) feeds the enable of the next, more significant
// stage so chained digits all step on the same clock edge.
// Optional build macro DOWN_COUNTER_SATURATE_EN: the count holds at zero
// instead of wrapping, and a registered done flag reports the 1->0 step.
// MODULUS must lie within 2..2**WIDTH.
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = COUNT_WIDTH,
  parameter int MODULUS = MOD_BIN4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             preset,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow
`ifdef DOWN_COUNTER_SATURATE_EN
  ,
  output logic             done
`endif
);

  localparam int unsigned      MOD_U   = MODULUS;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

`ifdef DOWN_COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load beats preset beats decrement; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = WIDTH'(clamp_value(32'(data), MOD_U));
    end else if (preset) begin
      count_d = MAX_VAL;
    end else if (enable) begin
      count_d = WIDTH'(down_next(32'(count_q), MOD_U, SATURATE));
    end
  end

  // Count register; clear forces zero regardless of the other controls.
  always_ff @(posedge clock) begin
    if (!clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q      = count_q;
  assign zero   = (count_q == '0);
  assign borrow = enable & zero;

`ifdef DOWN_COUNTER_SATURATE_EN
  logic done_q;

  // done latches on the enabled 1->0 step and stays until clear/load/preset.
  always_ff @(posedge clock) begin
    if (!clear) begin
      done_q <= 1'b0;
    end else if (load || preset) begin
      done_q <= 1'b0;
    end else if (enable && (count_q == ONE_VAL)) begin
      done_q <= 1'b1;
    end
  end

  assign done = done_q;
`else
  // Keep the unused constant referenced so the wrap build stays warning free.
  logic unused_one;
  assign unused_one = ^ONE_VAL;
`endif

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: a 16-state binary instance, a BCD
// instance, and a two-digit BCD cascade, against a behavioural model.
module tb_down_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       clear = 1'b1;
  // binary (MODULUS 16) instance
  logic       a_en = 0, a_load = 0, a_preset = 0;
  logic [3:0] a_data = 0, a_q;
  logic       a_zero, a_borrow;
  // BCD instance
  logic       b_en = 0, b_load = 0, b_preset = 0;
  logic [3:0] b_data = 0, b_q;
  logic       b_zero, b_borrow;
  // cascade
  logic       c_en = 0, c_preset = 0;
  logic [3:0] lo_q, hi_q;
  logic       lo_zero, lo_borrow, hi_zero, hi_borrow;
`ifdef DOWN_COUNTER_SATURATE_EN
  logic a_done, b_done, lo_done, hi_done;
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int ma, mb;  // model counts for a and b

  down_counter #(.WIDTH(4), .MODULUS(16)) u_a (
    .clock(clock), .clear(clear), .enable(a_en), .load(a_load), .data(a_data),
    .preset(a_preset), .q(a_q), .zero(a_zero), .borrow(a_borrow)
`ifdef DOWN_COUNTER_SATURATE_EN
    , .done(a_done)
`endif
  );

  down_counter #(.WIDTH(4), .MODULUS(10)) u_b (
    .clock(clock), .clear(clear), .enable(b_en), .load(b_load), .data(b_data),
    .preset(b_preset), .q(b_q), .zero(b_zero), .borrow(b_borrow)
`ifdef DOWN_COUNTER_SATURATE_EN
    , .done(b_done)
`endif
  );

  down_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clock(clock), .clear(clear), .enable(c_en), .load(1'b0), .data(4'd0),
    .preset(c_preset), .q(lo_q), .zero(lo_zero), .borrow(lo_borrow)
`ifdef DOWN_COUNTER_SATURATE_EN
    , .done(lo_done)
`endif
  );

  down_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clock(clock), .clear(clear), .enable(lo_borrow), .load(1'b0), .data(4'd0),
    .preset(c_preset), .q(hi_q), .zero(hi_zero), .borrow(hi_borrow)
`ifdef DOWN_COUNTER_SATURATE_EN
    , .done(hi_done)
`endif
  );

  // Behavioural next-count rule, straight from the priority list.
  function automatic int model_next(int cur, int modulus, bit clr, bit ld,
                                    int d, bit pr, bit en);
    if (!clr) return 0;
    if (ld) return (d >= modulus) ? modulus - 1 : d;
    if (pr) return modulus - 1;
    if (en) begin
      if (cur == 0) return SAT ? 0 : modulus - 1;
      return cur - 1;
    end
    return cur;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; a_en = 0; b_en = 0; c_en = 0;
    tick();
    clear = 1'b1;
    ma = 0; mb = 0;
    #1;
    checks++;
    if (a_q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", a_q); end
    checks++;
    if (a_zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", a_zero); end
    checks++;
    if (a_borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow_en0: got %b want 0", a_borrow); end
    a_en = 1'b1;
    #1;
    checks++;
    if (a_borrow !== 1'b1) begin errors++; $display("FAIL reset_borrow_en1: got %b want 1", a_borrow); end
    a_en = 1'b0;
  endtask

  task automatic test_free_run();
    int exp;
    a_en = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp = SAT ? 0 : (16 - (k % 16)) % 16;
      ma = exp;
      checks++;
      if (a_q !== 4'(exp)) begin errors++; $display("FAIL free_run_q edge %0d: got %0d want %0d", k, a_q, exp); end
      checks++;
      if (a_borrow !== (exp == 0)) begin errors++; $display("FAIL free_run_borrow edge %0d: got %b want %b", k, a_borrow, exp == 0); end
    end
    a_en = 1'b0;
  endtask

  task automatic test_bcd_load();
    int exp_seq [4];
    exp_seq = '{2, 1, 0, SAT ? 0 : 9};
    b_load = 1'b1; b_data = 4'd12;
    tick();
    checks++;
    if (b_q !== 4'd9) begin errors++; $display("FAIL bcd_clamp: got %0d want 9", b_q); end
    b_data = 4'd3;
    tick();
    checks++;
    if (b_q !== 4'd3) begin errors++; $display("FAIL bcd_load3: got %0d want 3", b_q); end
    b_load = 1'b0; b_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (b_q !== 4'(exp_seq[k])) begin errors++; $display("FAIL bcd_count step %0d: got %0d want %0d", k, b_q, exp_seq[k]); end
    end
    b_en = 1'b0;
    mb = exp_seq[3];
  endtask

  task automatic test_priority();
    a_load = 1; a_preset = 1; a_en = 1; a_data = 4'd5;
    tick();
    checks++;
    if (a_q !== 4'd5) begin errors++; $display("FAIL prio_load_wins: got %0d want 5", a_q); end
    a_load = 0; a_en = 0;
    tick();
    checks++;
    if (a_q !== 4'd15) begin errors++; $display("FAIL prio_preset: got %0d want 15", a_q); end
    a_preset = 0; a_load = 1; clear = 0;
    tick();
    checks++;
    if (a_q !== 4'd0) begin errors++; $display("FAIL prio_clear: got %0d want 0", a_q); end
    checks++;
    if (b_q !== 4'd0) begin errors++; $display("FAIL prio_clear_b: got %0d want 0", b_q); end
    clear = 1; a_load = 0;
    ma = 0; mb = 0;
  endtask

  task automatic test_cascade();
    int exp, got;
    c_preset = 1'b1;
    tick();
    c_preset = 1'b0;
    got = int'(hi_q) * 10 + int'(lo_q);
    checks++;
    if (got !== 99) begin errors++; $display("FAIL cascade_preset: got %0d want 99", got); end
    c_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      exp = (199 - k) % 100;
      got = int'(hi_q) * 10 + int'(lo_q);
      checks++;
      if (got !== exp || lo_q > 4'd9 || hi_q > 4'd9) begin
        errors++;
        $display("FAIL cascade_count edge %0d: got %0d%0d want %0d", k, hi_q, lo_q, exp);
      end
    end
    c_en = 1'b0;
  endtask

  task automatic test_random();
    bit clr, la, pa, ea, lb, pb, eb;
    int da, db;
    for (int n = 0; n < 300; n++) begin
      clr = ($urandom_range(0, 19) != 0);
      la = ($urandom_range(0, 7) == 0); pa = ($urandom_range(0, 7) == 0);
      ea = $urandom_range(0, 1) == 1;   da = $urandom_range(0, 15);
      lb = ($urandom_range(0, 7) == 0); pb = ($urandom_range(0, 7) == 0);
      eb = $urandom_range(0, 1) == 1;   db = $urandom_range(0, 15);
      clear = clr;
      a_load = la; a_preset = pa; a_en = ea; a_data = 4'(da);
      b_load = lb; b_preset = pb; b_en = eb; b_data = 4'(db);
      #1;
      checks++;
      if (a_borrow !== (ea && ma == 0) || b_borrow !== (eb && mb == 0)) begin
        errors++;
        $display("FAIL rand_borrow %0d: got a=%b b=%b want a=%b b=%b", n, a_borrow, b_borrow, ea && ma == 0, eb && mb == 0);
      end
      ma = model_next(ma, 16, clr, la, da, pa, ea);
      mb = model_next(mb, 10, clr, lb, db, pb, eb);
      tick();
      checks++;
      if (a_q !== 4'(ma) || a_zero !== (ma == 0)) begin
        errors++; $display("FAIL rand_a %0d: got q=%0d z=%b want q=%0d", n, a_q, a_zero, ma);
      end
      checks++;
      if (b_q !== 4'(mb) || b_zero !== (mb == 0)) begin
        errors++; $display("FAIL rand_b %0d: got q=%0d z=%b want q=%0d", n, b_q, b_zero, mb);
      end
    end
    clear = 1; a_load = 0; a_preset = 0; a_en = 0; b_load = 0; b_preset = 0; b_en = 0;
  endtask

`ifdef DOWN_COUNTER_SATURATE_EN
  task automatic test_saturate();
    int  exp_q [4];
    bit  exp_d [4];
    exp_q = '{1, 0, 0, 0};
    exp_d = '{0, 1, 1, 1};
    a_load = 1; a_data = 4'd2;
    tick();
    a_load = 0; a_en = 1;
    checks++;
    if (a_done !== 1'b0) begin errors++; $display("FAIL sat_done_after_load: got %b want 0", a_done); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (a_q !== 4'(exp_q[k]) || a_done !== exp_d[k]) begin
        errors++; $display("FAIL sat_step %0d: got q=%0d done=%b want q=%0d done=%b", k, a_q, a_done, exp_q[k], exp_d[k]);
      end
    end
    checks++;
    if (a_borrow !== 1'b1) begin errors++; $display("FAIL sat_borrow: got %b want 1", a_borrow); end
    a_en = 0; a_load = 1; a_data = 4'd7;
    tick();
    a_load = 0;
    checks++;
    if (a_done !== 1'b0 || a_q !== 4'd7) begin errors++; $display("FAIL sat_load_clears_done: got done=%b q=%0d want done=0 q=7", a_done, a_q); end
    ma = 7;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_bcd_load();
    test_priority();
`ifndef DOWN_COUNTER_SATURATE_EN
    test_cascade();
`endif
`ifdef DOWN_COUNTER_SATURATE_EN
    test_saturate();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
